page_fault_handler: RTL and testbench

Client-side counterpart of the physical frame allocator: services page faults by requesting a frame, and evicts the oldest resident page (FIFO replacement) when the allocator is out of memory. Installs and invalidates PTEs through a single write port and reports completion per fault. Sits between the MMU fault path and the page frame allocator / page table store.

---
 rtl/vm_pkg.sv | 22 ++
 rtl/resident_fifo.sv | 52 +++++
 rtl/page_fault_handler.sv | 178 +++++++++++++++++
 tb/tb_page_fault_handler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared types for the page fault handler: FSM state encoding, default widths
// and the resident-page FIFO entry layout.
package vm_pkg;

  localparam int PFH_VPN_BITS   = 8;
  localparam int PFH_FRAME_BITS = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ALLOC      = 3'd1,
    EVICT_INV  = 3'd2,
    EVICT_FREE = 3'd3,
    MAP        = 3'd4,
    DONE       = 3'd5
  } pfh_state_t;

  typedef struct packed {
    logic [PFH_VPN_BITS-1:0]   vpn;
    logic [PFH_FRAME_BITS-1:0] frame;
  } resident_entry_t;

endpackage

// File: rtl/resident_fifo.sv
// Synchronous FIFO of resident pages in install order; head is the oldest
// entry and is valid combinationally. Pushes while full are dropped.
module resident_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/page_fault_handler.sv
// Services MMU page faults: allocates a frame, evicting the oldest resident
// page (FIFO order) when the allocator is exhausted. Optional PFH_STATS_EN adds counters.
module page_fault_handler
  import vm_pkg::*;
#(
  parameter int VPN_BITS   = PFH_VPN_BITS,
  parameter int FRAME_BITS = PFH_FRAME_BITS,
  parameter int NUM_FRAMES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fault_valid,
  output logic                  fault_ready,
  input  logic [VPN_BITS-1:0]   fault_vpn,
  output logic                  alloc_req,
  input  logic                  alloc_valid,
  input  logic [FRAME_BITS-1:0] alloc_frame,
  output logic                  dealloc_req,
  output logic [FRAME_BITS-1:0] dealloc_frame,
  input  logic                  dealloc_valid,
  output logic                  pte_wr_en,
  output logic [VPN_BITS-1:0]   pte_wr_vpn,
  output logic [FRAME_BITS-1:0] pte_wr_frame,
  output logic                  pte_wr_present,
  output logic                  done_valid,
  output logic [VPN_BITS-1:0]   done_vpn,
  output logic [FRAME_BITS-1:0] done_frame,
  output logic                  done_evicted,
  output logic                  done_err
`ifdef PFH_STATS_EN
  ,
  output logic [31:0]           stat_faults,
  output logic [31:0]           stat_evictions,
  output logic [31:0]           stat_errors
`endif
);

  localparam int EW = VPN_BITS + FRAME_BITS;

  pfh_state_t state_q, state_d;
  logic [VPN_BITS-1:0]   vpn_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic [VPN_BITS-1:0]   victim_vpn_q;
  logic [FRAME_BITS-1:0] victim_frame_q;
  logic                  evicted_q;
  logic                  err_q;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [EW-1:0]         fifo_head;

  // A release of an already-free frame is harmless, so the ack is not acted on.
  logic unused_dealloc_valid;
  assign unused_dealloc_valid = dealloc_valid;

  resident_fifo #(.WIDTH(EW), .DEPTH(NUM_FRAMES)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({vpn_q, frame_q}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign fifo_push = (state_q == MAP) && !fifo_full;
  assign fifo_pop  = (state_q == EVICT_FREE);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (fault_valid) state_d = ALLOC;
      ALLOC: begin
        if (alloc_valid)      state_d = MAP;
        else if (!fifo_empty) state_d = EVICT_INV;
        else                  state_d = DONE;
      end
      EVICT_INV:  state_d = EVICT_FREE;
      EVICT_FREE: state_d = ALLOC;
      MAP:        state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    fault_ready    = 1'b0;
    alloc_req      = 1'b0;
    dealloc_req    = 1'b0;
    dealloc_frame  = '0;
    pte_wr_en      = 1'b0;
    pte_wr_vpn     = '0;
    pte_wr_frame   = '0;
    pte_wr_present = 1'b0;
    done_valid     = 1'b0;
    done_vpn       = '0;
    done_frame     = '0;
    done_evicted   = 1'b0;
    done_err       = 1'b0;
    case (state_q)
      IDLE:  fault_ready = 1'b1;
      ALLOC: alloc_req   = 1'b1;
      EVICT_INV: begin
        pte_wr_en    = 1'b1;
        pte_wr_vpn   = victim_vpn_q;
        pte_wr_frame = victim_frame_q;
      end
      EVICT_FREE: begin
        dealloc_req   = 1'b1;
        dealloc_frame = victim_frame_q;
      end
      MAP: begin
        pte_wr_en      = 1'b1;
        pte_wr_vpn     = vpn_q;
        pte_wr_frame   = frame_q;
        pte_wr_present = 1'b1;
      end
      DONE: begin
        done_valid   = 1'b1;
        done_vpn     = vpn_q;
        done_frame   = err_q ? '0 : frame_q;
        done_evicted = evicted_q;
        done_err     = err_q;
      end
      default: ;
    endcase
  end

  // Datapath captures carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && fault_valid) vpn_q <= fault_vpn;
    if (state_q == ALLOC && alloc_valid) frame_q <= alloc_frame;
    if (state_q == ALLOC && !alloc_valid && !fifo_empty) begin
      victim_vpn_q   <= fifo_head[EW-1:FRAME_BITS];
      victim_frame_q <= fifo_head[FRAME_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evicted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == IDLE && fault_valid) begin
        evicted_q <= 1'b0;
        err_q     <= 1'b0;
      end
      if (state_q == EVICT_FREE) evicted_q <= 1'b1;
      if (state_q == ALLOC && !alloc_valid && fifo_empty) err_q <= 1'b1;
    end
  end

`ifdef PFH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_faults    <= '0;
      stat_evictions <= '0;
      stat_errors    <= '0;
    end else begin
      if (state_q == DONE)          stat_faults    <= sat_inc(stat_faults);
      if (state_q == EVICT_FREE)    stat_evictions <= sat_inc(stat_evictions);
      if (state_q == DONE && err_q) stat_errors    <= sat_inc(stat_errors);
    end
  end
`endif

endmodule

// File: tb/tb_page_fault_handler.sv
// Directed bench for page_fault_handler with a 4-frame lowest-free allocator model.
module tb_page_fault_handler;
  import vm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fault_valid;
  logic       fault_ready;
  logic [7:0] fault_vpn;
  logic       alloc_req;
  logic       alloc_valid;
  logic [1:0] alloc_frame;
  logic       dealloc_req;
  logic [1:0] dealloc_frame;
  logic       dealloc_valid;
  logic       pte_wr_en;
  logic [7:0] pte_wr_vpn;
  logic [1:0] pte_wr_frame;
  logic       pte_wr_present;
  logic       done_valid;
  logic [7:0] done_vpn;
  logic [1:0] done_frame;
  logic       done_evicted;
  logic       done_err;
`ifdef PFH_STATS_EN
  logic [31:0] stat_faults, stat_evictions, stat_errors;
`endif

  logic [3:0] alloc_used;
  logic [3:0] ext_used;
  logic [3:0] used;
  int n_chk  = 0;
  int n_pass = 0;
  int n_done = 0;

  page_fault_handler #(.VPN_BITS(8), .FRAME_BITS(2), .NUM_FRAMES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .fault_valid(fault_valid), .fault_ready(fault_ready), .fault_vpn(fault_vpn),
    .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_frame(alloc_frame),
    .dealloc_req(dealloc_req), .dealloc_frame(dealloc_frame), .dealloc_valid(dealloc_valid),
    .pte_wr_en(pte_wr_en), .pte_wr_vpn(pte_wr_vpn), .pte_wr_frame(pte_wr_frame),
    .pte_wr_present(pte_wr_present),
    .done_valid(done_valid), .done_vpn(done_vpn), .done_frame(done_frame),
    .done_evicted(done_evicted), .done_err(done_err)
`ifdef PFH_STATS_EN
    , .stat_faults(stat_faults), .stat_evictions(stat_evictions), .stat_errors(stat_errors)
`endif
  );

  always #5 clk = ~clk;

  // Allocator model: grants the lowest free frame in the request cycle.
  assign used = alloc_used | ext_used;
  always_comb begin
    alloc_frame = 2'd0;
    for (int i = 3; i >= 0; i--) if (!used[i]) alloc_frame = 2'(i);
    alloc_valid   = alloc_req && (used != 4'hF);
    dealloc_valid = dealloc_req && alloc_used[dealloc_frame];
  end

  always @(posedge clk) begin
    if (!rst_n) alloc_used <= 4'h0;
    else begin
      if (alloc_req && alloc_valid) alloc_used[alloc_frame] <= 1'b1;
      if (dealloc_req) alloc_used[dealloc_frame] <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (done_valid) n_done++;
    if (rst_n) begin
      chk("alloc_dealloc_excl", 32'(alloc_req && dealloc_req), 32'd0);
      chk("pte_state", 32'(pte_wr_en && !(dut.state_q == EVICT_INV || dut.state_q == MAP)), 32'd0);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    fault_valid = 1'b0;
    fault_vpn = 8'h00;
    ext_used = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_fault(input logic [7:0] vpn, input logic [1:0] frm, input bit ev,
                           input logic [7:0] vvpn, input logic [1:0] vfrm);
    fault_valid = 1'b1;
    fault_vpn = vpn;
    @(negedge clk); chk("ready_idle", 32'(fault_ready), 32'd1);
    @(posedge clk); #1 fault_valid = 1'b0;
    @(negedge clk);
    chk("alloc_req", 32'(alloc_req), 32'd1);
    chk("alloc_grant", 32'(alloc_valid), 32'(!ev));
    chk("ready_busy", 32'(fault_ready), 32'd0);
    if (ev) begin
      @(negedge clk);
      chk("inv_en", 32'(pte_wr_en), 32'd1);
      chk("inv_present", 32'(pte_wr_present), 32'd0);
      chk("inv_vpn", 32'(pte_wr_vpn), 32'(vvpn));
      chk("inv_frame", 32'(pte_wr_frame), 32'(vfrm));
      @(negedge clk);
      chk("free_req", 32'(dealloc_req), 32'd1);
      chk("free_frame", 32'(dealloc_frame), 32'(vfrm));
      chk("free_valid", 32'(dealloc_valid), 32'd1);
      chk("free_no_pte", 32'(pte_wr_en), 32'd0);
      @(negedge clk);
      chk("realloc_grant", 32'(alloc_valid), 32'd1);
    end
    @(negedge clk);
    chk("map_en", 32'(pte_wr_en), 32'd1);
    chk("map_present", 32'(pte_wr_present), 32'd1);
    chk("map_vpn", 32'(pte_wr_vpn), 32'(vpn));
    chk("map_frame", 32'(pte_wr_frame), 32'(frm));
    chk("map_no_done", 32'(done_valid), 32'd0);
    @(negedge clk);
    chk("done_valid", 32'(done_valid), 32'd1);
    chk("done_vpn", 32'(done_vpn), 32'(vpn));
    chk("done_frame", 32'(done_frame), 32'(frm));
    chk("done_evicted", 32'(done_evicted), 32'(ev));
    chk("done_err", 32'(done_err), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done_valid), 32'd0);
    chk("done_vpn_zero", 32'(done_vpn), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_err(input logic [7:0] vpn);
    fault_valid = 1'b1;
    fault_vpn = vpn;
    @(negedge clk); chk("err_ready", 32'(fault_ready), 32'd1);
    @(posedge clk); #1 fault_valid = 1'b0;
    @(negedge clk);
    chk("err_alloc_req", 32'(alloc_req), 32'd1);
    chk("err_no_grant", 32'(alloc_valid), 32'd0);
    chk("err_no_pte_a", 32'(pte_wr_en), 32'd0);
    @(negedge clk);
    chk("err_done", 32'(done_valid), 32'd1);
    chk("err_flag", 32'(done_err), 32'd1);
    chk("err_vpn", 32'(done_vpn), 32'(vpn));
    chk("err_frame", 32'(done_frame), 32'd0);
    chk("err_evicted", 32'(done_evicted), 32'd0);
    chk("err_no_pte_d", 32'(pte_wr_en), 32'd0);
    chk("err_no_dealloc", 32'(dealloc_req), 32'd0);
    @(posedge clk); #1;
  endtask

  int base;

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_ready", 32'(fault_ready), 32'd1);
    chk("rst_alloc", 32'(alloc_req), 32'd0);
    chk("rst_dealloc", 32'(dealloc_req), 32'd0);
    chk("rst_pte", 32'(pte_wr_en), 32'd0);
    chk("rst_done", 32'(done_valid), 32'd0);
    @(posedge clk); #1;

    run_fault(8'h10, 2'd0, 1'b0, 8'h00, 2'd0);
    run_fault(8'h11, 2'd1, 1'b0, 8'h00, 2'd0);
    run_fault(8'h12, 2'd2, 1'b0, 8'h00, 2'd0);
    run_fault(8'h13, 2'd3, 1'b0, 8'h00, 2'd0);
    run_fault(8'h14, 2'd0, 1'b1, 8'h10, 2'd0);
    run_fault(8'h15, 2'd1, 1'b1, 8'h11, 2'd1);

    // Back-to-back with fault_valid held high.
    do_reset();
    @(posedge clk); #1;
    base = n_done;
    fault_valid = 1'b1;
    fault_vpn = 8'h30;
    @(negedge clk); chk("b2b_ready0", 32'(fault_ready), 32'd1);
    @(posedge clk); #1 fault_vpn = 8'h31;
    @(negedge clk); chk("b2b_busy_a", 32'(fault_ready), 32'd0);
    @(negedge clk); chk("b2b_map0_vpn", 32'(pte_wr_vpn), 32'h30);
    chk("b2b_busy_m", 32'(fault_ready), 32'd0);
    @(negedge clk); chk("b2b_done0_vpn", 32'(done_vpn), 32'h30);
    chk("b2b_busy_d", 32'(fault_ready), 32'd0);
    @(negedge clk); chk("b2b_ready1", 32'(fault_ready), 32'd1);
    @(posedge clk); #1 fault_valid = 1'b0;
    @(negedge clk); chk("b2b_busy1", 32'(fault_ready), 32'd0);
    @(negedge clk); chk("b2b_map1_vpn", 32'(pte_wr_vpn), 32'h31);
    chk("b2b_map1_frame", 32'(pte_wr_frame), 32'd1);
    @(negedge clk); chk("b2b_done1_vpn", 32'(done_vpn), 32'h31);
    chk("b2b_done1_frame", 32'(done_frame), 32'd1);
    repeat (4) @(negedge clk);
    chk("b2b_done_count", 32'(n_done - base), 32'd2);
    @(posedge clk); #1;

    // Allocator exhausted by other clients, nothing resident to evict.
    do_reset();
    @(posedge clk); #1;
    ext_used = 4'hF;
    run_err(8'h20);

    // Reset asserted while releasing a victim frame.
    do_reset();
    @(posedge clk); #1;
    run_fault(8'h40, 2'd0, 1'b0, 8'h00, 2'd0);
    run_fault(8'h41, 2'd1, 1'b0, 8'h00, 2'd0);
    run_fault(8'h42, 2'd2, 1'b0, 8'h00, 2'd0);
    run_fault(8'h43, 2'd3, 1'b0, 8'h00, 2'd0);
    fault_valid = 1'b1;
    fault_vpn = 8'h44;
    @(posedge clk); #1 fault_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_in_free", 32'(dealloc_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_ready", 32'(fault_ready), 32'd1);
    chk("mid_alloc", 32'(alloc_req), 32'd0);
    chk("mid_dealloc", 32'(dealloc_req), 32'd0);
    chk("mid_pte", 32'(pte_wr_en), 32'd0);
    chk("mid_done", 32'(done_valid), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    ext_used = 4'hF;
    run_err(8'h50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
